noc_inject_arbiter: RTL and testbench
=====================================

// Module: noc_inject_arbiter
// PURPOSE
//  Packet-atomic (wormhole) round-robin arbiter sharing one NoC router injection channel among NUM_REQ local requesters.
//  Sits between local endpoints and the Noc_<x>_<y>_channel0 receive port.
//  Once a requester wins with a header flit, it owns the channel until its tail flit is accepted.
//  The selected flit is driven through a one-entry output register.
// PARAMETERS
//  NUM_REQ   4                 number of requesters, >=2
//  FLIT_W    `Noc_Data_Width   flit width in bits
//  IDX_W     $clog2(NUM_REQ)   grant index width (derived, do not override)
// PORTS
//  noc_clk          in   1               clock, all logic on rising edge
//  rst              in   1               synchronous, active-high reset
//  req_valid        in   NUM_REQ         per-requester flit valid
//  req_ready        out  NUM_REQ         per-requester flit accepted (combinational)
//  req_flit         in   NUM_REQ*FLIT_W  requester i occupies bits [i*FLIT_W +: FLIT_W]
//  req_is_header    in   NUM_REQ         flit is the packet header
//  req_is_tail      in   NUM_REQ         flit is the packet tail (header+tail = single-flit packet)
//  out_valid        out  1               registered flit valid toward router
//  out_ready        in   1               router accepts out flit this cycle
//  out_flit         out  FLIT_W          registered flit
//  out_VCready      in   1               router VC free; required to start a new packet
//  out_is_header    out  1               registered header marker
//  out_is_tail      out  1               registered tail marker
//  grant_idx        out  IDX_W           current/last owner
//  busy             out  1               state==LOCKED
//  proto_err        out  1               sticky: non-header flit offered in IDLE
//  pkt_count        out  16              packets completed; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset values:
//    - out_valid, out_flit, out_is_header, out_is_tail, busy, proto_err, pkt_count, grant_idx = 0.
//    - RR pointer = 0; state = IDLE.
//  - Reset mid-packet drops the held flit and releases ownership; no flush.
//  - can_load = !out_valid | out_ready. The output register loads only when a req_ready bit is 1.
//    - If out_ready=1 and nothing loads: out_valid -> 0.
//    - Otherwise out_valid holds.
//  - Latency: an accepted flit appears on out_* the next cycle.
//  - Throughput: 1 flit/cycle while out_ready=1.
//  - IDLE:
//    - eligible[i] = req_valid[i] & req_is_header[i].
//    - If any eligible bit is set, out_VCready=1 and can_load=1:
//      - winner = first eligible index at or after the RR pointer (circular).
//      - req_ready[winner]=1 in the same cycle.
//      - grant_idx <= winner; pointer <= (winner+1) mod NUM_REQ.
//      - If the header is also a tail: stay IDLE and increment pkt_count.
//      - Otherwise go to LOCKED.
//    - If out_VCready=0 or can_load=0: no req_ready and no pointer change.
//    - Any req_valid[i] & !req_is_header[i] in IDLE sets proto_err (sticky until reset); that flit is never accepted.
//  - LOCKED:
//    - req_ready[grant_idx] = can_load; all other req_ready bits = 0.
//    - out_VCready is ignored.
//    - Headers from the owner are passed unchanged (no check).
//    - An accepted flit with req_is_tail=1 -> IDLE and pkt_count++.
//    - A requester may stall mid-packet (valid=0) indefinitely; ownership is kept.
//  - Simultaneous tail accept and a new header elsewhere:
//    - The new header waits for the next cycle (IDLE).
//    - Consequence: at least one bubble-free gap-less cycle is not required; one idle arbitration cycle is allowed.
//  - At most one req_ready bit is set per cycle.
//  - Flits are never duplicated or reordered.
//  - Out-of-range pointer is impossible: modulo wrap when NUM_REQ is not a power of 2.
// STRUCTURE
//  - Shared package noc_pkg: FLIT_W default macro binding and the state enum {IDLE=1'b0, LOCKED=1'b1}.
//  - Sub-module rr_pick: combinational (req vector, pointer) -> (any, index).
//    - Reused by future router output arbiters.
//  - Top holds the FSM, pointer, output register and counters.
// TESTING
//  1. Reset, then req0 sends a 3-flit packet (H,B,T), out_ready=1, out_VCready=1:
//     - out shows H,B,T on cycles 1-3 after acceptance.
//     - pkt_count=1, busy returns 0.
//  2. All 4 requesters hold single-flit packets continuously:
//     - grant order is 0,1,2,3,0.
//     - pointer wraps; each accepted once per 4 grants.
//  3. req1 owns a packet and req2 presents a header mid-packet:
//     - req_ready[2]=0 until req1's tail is accepted.
//     - req2 is granted in the next IDLE cycle.
//  4. out_ready=0 for 5 cycles with out_valid=1:
//     - out_flit is stable and req_ready is all 0.
//     - After release, flits resume in order with no loss.
//  5. out_VCready=0 with a header pending: no grant. Drop VCready while LOCKED: the packet still completes.
//  6. req3 offers a body flit in IDLE:
//     - proto_err=1 and stays set; the flit is not accepted.
//     - A rst pulse mid-packet clears all outputs and returns busy=0.

Source files
------------

// File: rtl/noc_inject_arbiter_pkg.sv
// Shared types and helpers for the NoC injection arbiter: flit width default,
// arbiter state encoding and a circular index increment.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

package noc_inject_arbiter_pkg;

  localparam int FLIT_W_DEFAULT = `Noc_Data_Width;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_e;

  // Circular successor, so a non-power-of-two requester count never yields an out-of-range pointer
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Requester-side and router-side handshake bundle of the injection arbiter.
interface noc_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_VCready;
  logic                      out_is_header;
  logic                      out_is_tail;

  modport slave (
    input  req_valid, req_flit, req_is_header, req_is_tail, out_ready, out_VCready,
    output req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

  modport master (
    output req_valid, req_flit, req_is_header, req_is_tail, out_ready, out_VCready,
    input  req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );
endinterface

// File: rtl/noc_inject_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, circularly.
module noc_inject_arbiter_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan offsets from farthest to nearest so the nearest hit is the one left standing
  always_comb begin
    int j;
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-atomic round-robin arbiter feeding one router injection channel through
// a one-entry output register.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int FLIT_W  = FLIT_W_DEFAULT,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 noc_clk,
  input  logic                 rst,
  noc_inject_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 proto_err,
  output logic [15:0]          pkt_count
);

  arbState_e          state_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d, grant_q;
  logic               outValid_q, outHeader_q, outTail_q, protoErr_q;
  logic [FLIT_W-1:0]  outFlit_q;
  logic [15:0]        pktCount_q, pktCount_d;

  logic [NUM_REQ-1:0] eligible, readyVec;
  logic               anyElig, canLoad, accept, selTail, selHeader;
  logic [IDX_W-1:0]   win, selIdx;
  logic [FLIT_W-1:0]  selFlit;

  assign eligible = bus.req_valid & bus.req_is_header;
  assign canLoad  = !outValid_q || bus.out_ready;

  noc_inject_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .any_o (anyElig),
    .idx_o (win)
  );

  // In IDLE the picker's winner is the candidate; in LOCKED only the owner may move
  always_comb begin
    readyVec = '0;
    selIdx   = grant_q;
    if (state_q == IDLE) begin
      selIdx = win;
      if (anyElig && bus.out_VCready && canLoad) readyVec[win] = 1'b1;
    end else begin
      readyVec[grant_q] = canLoad;
    end
  end

  assign bus.req_ready = readyVec;
  assign accept        = |(readyVec & bus.req_valid);
  assign selFlit       = bus.req_flit[int'(selIdx)*FLIT_W +: FLIT_W];
  assign selTail       = bus.req_is_tail[selIdx];
  assign selHeader     = bus.req_is_header[selIdx];
  assign ptr_d         = IDX_W'(wrapInc(int'(win), NUM_REQ));
  assign pktCount_d    = pktCount_q + 16'd1;

  always_ff @(posedge noc_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      outValid_q  <= 1'b0;
      outFlit_q   <= '0;
      outHeader_q <= 1'b0;
      outTail_q   <= 1'b0;
      protoErr_q  <= 1'b0;
      pktCount_q  <= '0;
    end else begin
      if (accept) begin
        outValid_q  <= 1'b1;
        outFlit_q   <= selFlit;
        outHeader_q <= selHeader;
        outTail_q   <= selTail;
      end else if (bus.out_ready) begin
        outValid_q  <= 1'b0;
      end

      if (state_q == IDLE && |(bus.req_valid & ~bus.req_is_header)) protoErr_q <= 1'b1;

      // A tail closes the packet even when it is also the header
      if (accept) begin
        if (state_q == IDLE) begin
          grant_q <= win;
          ptr_q   <= ptr_d;
        end
        if (selTail) begin
          state_q    <= IDLE;
          pktCount_q <= pktCount_d;
        end else begin
          state_q    <= LOCKED;
        end
      end
    end
  end

  assign bus.out_valid     = outValid_q;
  assign bus.out_flit      = outFlit_q;
  assign bus.out_is_header = outHeader_q;
  assign bus.out_is_tail   = outTail_q;
  assign grant_idx         = grant_q;
  assign busy              = (state_q == LOCKED);
  assign proto_err         = protoErr_q;
  assign pkt_count         = pktCount_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for the injection arbiter: packet flow, round-robin order,
// ownership, back-pressure, VC gating, protocol error and reset.
module tb_noc_inject_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FLIT_W  = 32;

  logic        noc_clk;
  logic        rst;
  logic [1:0]  grant_idx;
  logic        busy;
  logic        proto_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  noc_inject_arbiter_if #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) bus ();

  noc_inject_arbiter #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W)) dut (
    .noc_clk   (noc_clk),
    .rst       (rst),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy),
    .proto_err (proto_err),
    .pkt_count (pkt_count)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [31:0] f,
                               input logic h, input logic t);
    bus.req_valid[i]              = v;
    bus.req_flit[i*FLIT_W +: FLIT_W] = f;
    bus.req_is_header[i]          = h;
    bus.req_is_tail[i]            = t;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearReqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.out_ready   = 1'b1;
    bus.out_VCready = 1'b1;
    doReset();

    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy",      32'(busy),          32'd0);
    checkOutput("rst_proto_err", 32'(proto_err),     32'd0);
    checkOutput("rst_pkt_count", 32'(pkt_count),     32'd0);
    checkOutput("rst_grant",     32'(grant_idx),     32'd0);

    // Three-flit packet from requester 0
    applyStimulus(0, 1'b1, 32'hA0, 1'b1, 1'b0);
    #1 checkOutput("t1_ready_h", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("t1_out_h",    bus.out_flit,           32'hA0);
    checkOutput("t1_out_hdr",  32'(bus.out_is_header), 32'd1);
    checkOutput("t1_busy",     32'(busy),              32'd1);
    applyStimulus(0, 1'b1, 32'hA1, 1'b0, 1'b0);
    #1 checkOutput("t1_ready_b", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("t1_out_b",    bus.out_flit,           32'hA1);
    applyStimulus(0, 1'b1, 32'hA2, 1'b0, 1'b1);
    tick();
    checkOutput("t1_out_t",    bus.out_flit,           32'hA2);
    checkOutput("t1_out_tail", 32'(bus.out_is_tail),   32'd1);
    checkOutput("t1_busy_end", 32'(busy),              32'd0);
    checkOutput("t1_pkt",      32'(pkt_count),         32'd1);
    clearReqs();
    tick();
    checkOutput("t1_drain", 32'(bus.out_valid), 32'd0);

    // Round-robin over four continuous single-flit requesters, pointer back at 0
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 32'hB0 + i, 1'b1, 1'b1);
    for (int g = 0; g < 5; g++) begin
      #1 checkOutput("t2_ready", 32'(bus.req_ready), 32'(1 << (g % 4)));
      tick();
      checkOutput("t2_grant", 32'(grant_idx), 32'(g % 4));
      checkOutput("t2_flit",  bus.out_flit,   32'hB0 + 32'(g % 4));
    end
    checkOutput("t2_pkt", 32'(pkt_count), 32'd5);
    clearReqs();

    // Requester 1 owns the channel while requester 2 waits with a header
    applyStimulus(1, 1'b1, 32'hC0, 1'b1, 1'b0);
    tick();
    checkOutput("t3_grant1", 32'(grant_idx), 32'd1);
    applyStimulus(1, 1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 32'hD0, 1'b1, 1'b1);
    #1 checkOutput("t3_ready_body", 32'(bus.req_ready), 32'h2);
    tick();
    applyStimulus(1, 1'b1, 32'hC2, 1'b0, 1'b1);
    #1 checkOutput("t3_ready_tail", 32'(bus.req_ready), 32'h2);
    tick();
    checkOutput("t3_out_tail", bus.out_flit, 32'hC2);
    checkOutput("t3_idle",     32'(busy),    32'd0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
    #1 checkOutput("t3_ready_req2", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("t3_grant2", 32'(grant_idx), 32'd2);
    checkOutput("t3_flit2",  bus.out_flit,   32'hD0);
    clearReqs();

    // Router back-pressure holds the output register and all readies low
    applyStimulus(3, 1'b1, 32'hE0, 1'b1, 1'b0);
    tick();
    checkOutput("t4_first", bus.out_flit, 32'hE0);
    bus.out_ready = 1'b0;
    applyStimulus(3, 1'b1, 32'hE1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1 checkOutput("t4_stall_ready", 32'(bus.req_ready), 32'h0);
      tick();
      checkOutput("t4_stall_flit",  bus.out_flit,        32'hE0);
      checkOutput("t4_stall_valid", 32'(bus.out_valid),  32'd1);
    end
    bus.out_ready = 1'b1;
    #1 checkOutput("t4_release_ready", 32'(bus.req_ready), 32'h8);
    tick();
    checkOutput("t4_body", bus.out_flit, 32'hE1);
    applyStimulus(3, 1'b1, 32'hE2, 1'b0, 1'b1);
    tick();
    checkOutput("t4_tail", bus.out_flit, 32'hE2);
    checkOutput("t4_pkt",  32'(pkt_count), 32'd8);
    clearReqs();

    // VC gating only blocks packet start
    bus.out_VCready = 1'b0;
    applyStimulus(0, 1'b1, 32'hF0, 1'b1, 1'b0);
    #1 checkOutput("t5_no_grant", 32'(bus.req_ready), 32'h0);
    tick();
    checkOutput("t5_idle",  32'(busy),          32'd0);
    checkOutput("t5_empty", 32'(bus.out_valid), 32'd0);
    bus.out_VCready = 1'b1;
    #1 checkOutput("t5_grant", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("t5_locked", 32'(busy), 32'd1);
    bus.out_VCready = 1'b0;
    applyStimulus(0, 1'b1, 32'hF1, 1'b0, 1'b1);
    #1 checkOutput("t5_locked_ready", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("t5_tail", bus.out_flit,   32'hF1);
    checkOutput("t5_pkt",  32'(pkt_count), 32'd9);
    clearReqs();
    bus.out_VCready = 1'b1;

    // Body flit offered with no owner, then reset in the middle of a packet
    applyStimulus(3, 1'b1, 32'h33, 1'b0, 1'b0);
    #1 checkOutput("t6_not_accepted", 32'(bus.req_ready), 32'h0);
    tick();
    checkOutput("t6_err_set", 32'(proto_err), 32'd1);
    clearReqs();
    tick();
    checkOutput("t6_err_sticky", 32'(proto_err), 32'd1);
    applyStimulus(1, 1'b1, 32'h11, 1'b1, 1'b0);
    tick();
    checkOutput("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearReqs();
    checkOutput("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_rst_flit",  bus.out_flit,       32'd0);
    checkOutput("t6_rst_busy",  32'(busy),          32'd0);
    checkOutput("t6_rst_err",   32'(proto_err),     32'd0);
    checkOutput("t6_rst_pkt",   32'(pkt_count),     32'd0);
    checkOutput("t6_rst_grant", 32'(grant_idx),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
